parity_frame_checker: RTL

PARITY_FRAME_CHECKER -- requirements
Module: parity_frame_checker

---
 rtl/parity_pkg.sv | 12 +
 rtl/parity_word.sv | 20 ++
 rtl/parity_frame_checker.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// Shared defaults and state encoding for the frame parity checker.
package parity_pkg;

    localparam int PAR_DATA_W_DEF = 16;
    localparam int PAR_CNT_W_DEF  = 8;

    typedef enum logic [0:0] {
        ACC  = 1'b0,
        HOLD = 1'b1
    } par_state_e;

endpackage : parity_pkg

// File: rtl/parity_word.sv
// Combinational reduction parity of one input word; odd weight gives 1.
module parity_word
    import parity_pkg::*;
#(
    parameter int DATA_W = PAR_DATA_W_DEF
) (
    input  logic [DATA_W-1:0] data,
    output logic              par
);

    logic par_s;

    // XOR-reduce all data bits
    always_comb begin
        par_s = ^data;
    end

    assign par = par_s;

endmodule : parity_word

// File: rtl/parity_frame_checker.sv
// Accumulates per-word parity over a frame, holds the result until taken,
// and keeps a saturating count of frames whose parity did not match.
module parity_frame_checker
    import parity_pkg::*;
#(
    parameter int DATA_W = PAR_DATA_W_DEF,
    parameter int CNT_W  = PAR_CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_par,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_par,
    output logic              res_err,
    output logic [CNT_W-1:0]  res_words,
    output logic [CNT_W-1:0]  err_cnt,
    input  logic              clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    par_state_e       state_r;
    par_state_e       state_nxt_s;
    logic             acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             res_par_r;
    logic             res_err_r;
    logic [CNT_W-1:0] res_words_r;
    logic [CNT_W-1:0] err_cnt_r;

    logic             word_par_s;
    logic             in_ready_s;
    logic             res_valid_s;
    logic             accept_s;
    logic             acc_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             frame_err_s;

    parity_word #(
        .DATA_W(DATA_W)
    ) u_parity_word (
        .data(in_data),
        .par (word_par_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ACC;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: a last-word handshake enters HOLD, a taken result returns to ACC
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ACC: begin
                if (accept_s && in_last) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = ACC;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_nxt_s = ACC;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: state_nxt_s = ACC;
        endcase
    end

    // Handshake outputs decoded from the state register only
    always_comb begin
        in_ready_s  = 1'b0;
        res_valid_s = 1'b0;
        case (state_r)
            ACC: begin
                in_ready_s  = 1'b1;
                res_valid_s = 1'b0;
            end
            HOLD: begin
                in_ready_s  = 1'b0;
                res_valid_s = 1'b1;
            end
            default: begin
                in_ready_s  = 1'b0;
                res_valid_s = 1'b0;
            end
        endcase
    end

    // Accumulator and word count including the word being accepted now
    always_comb begin
        accept_s    = in_valid && in_ready_s;
        acc_nxt_s   = acc_r ^ word_par_s;
        cnt_nxt_s   = sat_inc(cnt_r);
        frame_err_s = acc_nxt_s ^ in_par;
    end

    // Frame accumulation and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r       <= 1'b0;
            cnt_r       <= CNT_ZERO;
            res_par_r   <= 1'b0;
            res_err_r   <= 1'b0;
            res_words_r <= CNT_ZERO;
        end else if (accept_s) begin
            if (in_last) begin
                res_par_r   <= acc_nxt_s;
                res_err_r   <= frame_err_s;
                res_words_r <= cnt_nxt_s;
                acc_r       <= 1'b0;
                cnt_r       <= CNT_ZERO;
            end else begin
                acc_r <= acc_nxt_s;
                cnt_r <= cnt_nxt_s;
            end
        end else begin
            acc_r <= acc_r;
            cnt_r <= cnt_r;
        end
    end

    // Error counter; clear takes priority over a coincident increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= CNT_ZERO;
        end else if (clr) begin
            err_cnt_r <= CNT_ZERO;
        end else if (accept_s && in_last && frame_err_s) begin
            err_cnt_r <= sat_inc(err_cnt_r);
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign res_valid = res_valid_s;
    assign res_par   = res_par_r;
    assign res_err   = res_err_r;
    assign res_words = res_words_r;
    assign err_cnt   = err_cnt_r;

endmodule : parity_frame_checker
